// File: rtl/ps2_cmd_pkg.sv
// Shared types and constants for the PS/2 keyboard-to-command mapper.
// Holds the per-key repeat FSM states, direction slots and the default key map.
package ps2_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } rep_state_e;

    localparam int DIR_UP    = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_RIGHT = 3;

    localparam logic [8:0] KEY_W           = 9'h01D;
    localparam logic [8:0] KEY_A           = 9'h01C;
    localparam logic [8:0] KEY_S           = 9'h01B;
    localparam logic [8:0] KEY_D           = 9'h023;
    localparam logic [8:0] KEY_ARROW_UP    = 9'h175;
    localparam logic [8:0] KEY_ARROW_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_ARROW_DOWN  = 9'h172;
    localparam logic [8:0] KEY_ARROW_RIGHT = 9'h174;

    // Player 0 on WASD, player 1 on the extended arrow keys; LSB slot is P0 up.
    localparam logic [71:0] KEYMAP_DEFAULT = {
        KEY_ARROW_RIGHT, KEY_ARROW_DOWN, KEY_ARROW_LEFT, KEY_ARROW_UP,
        KEY_D, KEY_S, KEY_A, KEY_W
    };

    function automatic int key_idx(input int player, input int dir);
        return player * 4 + dir;
    endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Typematic repeat engine for one key: first pulse on press, then a delayed
// repeat stream while the key stays held.
module key_repeat_fsm
    import ps2_cmd_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic held,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    rep_state_e       r_state;
    rep_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_held_d;
    logic             w_cnt_zero;

    // State, counter and previous-held registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_held_d <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_held_d <= held;
        end
    end

    // Next-state and pulse decode; the pulse depends only on state so a
    // one-cycle tap still fires from FIRST even though held has already dropped
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cnt_zero   = (r_cnt == '0);
        case (r_state)
            ST_FIRST:  pulse = enable;
            ST_DELAY:  pulse = enable & w_cnt_zero;
            ST_REPEAT: pulse = enable & w_cnt_zero;
            default:   pulse = 1'b0;
        endcase
        if (!enable || !held) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_held_d) begin
                        w_state_next = ST_FIRST;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_FIRST: begin
                    w_cnt_next   = DELAY_LOAD;
                    w_state_next = ST_DELAY;
                end
                ST_DELAY: begin
                    if (w_cnt_zero) begin
                        w_cnt_next   = PERIOD_LOAD;
                        w_state_next = ST_REPEAT;
                    end else begin
                        w_cnt_next   = r_cnt - CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (w_cnt_zero) begin
                        w_cnt_next = PERIOD_LOAD;
                    end else begin
                        w_cnt_next = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_cmd_mapper.sv
// Maps the PS/2 held-key bitmap to per-player direction pulses with auto-repeat,
// opposite-direction cancellation, a facing register and an unmapped-key stop pulse.
module ps2_cmd_mapper
    import ps2_cmd_pkg::*;
#(
    parameter int                    PLAYERS       = 2,
    parameter logic [PLAYERS*36-1:0] KEYMAP        = (PLAYERS*36)'(KEYMAP_DEFAULT),
    parameter int                    REPEAT_DELAY  = 25_000_000,
    parameter int                    REPEAT_PERIOD = 5_000_000,
    parameter int                    CNT_W         = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   key_valid,
    input  logic [8:0]             last_change,
    input  logic [511:0]           key_down,
    output logic [PLAYERS-1:0]     cmd_up,
    output logic [PLAYERS-1:0]     cmd_left,
    output logic [PLAYERS-1:0]     cmd_down,
    output logic [PLAYERS-1:0]     cmd_right,
    output logic [PLAYERS*4-1:0]   held,
    output logic [PLAYERS-1:0]     facing,
    output logic                   stop
);

    localparam int NKEYS = PLAYERS * 4;

    logic [NKEYS-1:0]   r_held;
    logic [NKEYS-1:0]   w_pulse;
    logic [PLAYERS-1:0] w_mask_lr;
    logic [PLAYERS-1:0] w_mask_ud;
    logic [PLAYERS-1:0] r_facing;
    logic               r_stop;
    logic               w_match;

    // Sample each mapped key bit from the decoder bitmap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held <= '0;
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                r_held[k] <= key_down[KEYMAP[k*9 +: 9]];
            end
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_repeat_fsm #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_fsm (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .held   (r_held[k]),
            .pulse  (w_pulse[k])
        );
    end

    // Opposing keys held together cancel each other's pulses; FSMs keep running
    always_comb begin
        w_mask_lr = '0;
        w_mask_ud = '0;
        cmd_up    = '0;
        cmd_left  = '0;
        cmd_down  = '0;
        cmd_right = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            w_mask_lr[p] = r_held[key_idx(p, DIR_LEFT)] & r_held[key_idx(p, DIR_RIGHT)];
            w_mask_ud[p] = r_held[key_idx(p, DIR_UP)]   & r_held[key_idx(p, DIR_DOWN)];
            cmd_up[p]    = w_pulse[key_idx(p, DIR_UP)]    & ~w_mask_ud[p];
            cmd_down[p]  = w_pulse[key_idx(p, DIR_DOWN)]  & ~w_mask_ud[p];
            cmd_left[p]  = w_pulse[key_idx(p, DIR_LEFT)]  & ~w_mask_lr[p];
            cmd_right[p] = w_pulse[key_idx(p, DIR_RIGHT)] & ~w_mask_lr[p];
        end
    end

    // Does the latest key event hit any slot of the map
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            w_match = w_match | (KEYMAP[k*9 +: 9] == last_change);
        end
    end

    // Facing follows the last unmasked horizontal pulse; stop flags unmapped presses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_facing <= '1;
            r_stop   <= 1'b0;
        end else begin
            r_stop <= enable & key_valid & key_down[last_change] & ~w_match;
            for (int p = 0; p < PLAYERS; p++) begin
                if (cmd_right[p]) begin
                    r_facing[p] <= 1'b1;
                end else if (cmd_left[p]) begin
                    r_facing[p] <= 1'b0;
                end else begin
                    r_facing[p] <= r_facing[p];
                end
            end
        end
    end

    assign held   = r_held;
    assign facing = r_facing;
    assign stop   = r_stop;

endmodule
